serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new subtraction; sampled on rising edge.
REQ-005 a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 bin  input  1  borrow-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  high while an operation is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse; results valid and newly updated.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  borrow-out from the MSB (1 = unsigned a < b + bin).
REQ-012 ovf  output  1  signed two's-complement overflow of the subtraction.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE: start=1 -> latch a, b and bin into internal shift and borrow registers, clear the bit counter, go to RUN; start=0 -> stay in IDLE.
REQ-015 RUN: each edge processes one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~a0 & br) | (b0 & br).
REQ-016 RUN: the operand registers shift right one bit per edge, and d is shifted into a result shift register from the MSB side.
REQ-017 RUN: on the edge that processes bit WIDTH-1, the block loads diff, bout = br_next and ovf = br ^ br_next (borrow into MSB XOR borrow out of MSB) together, and the FSM goes to DONE.
REQ-018 DONE: done=1 for exactly this cycle; next state is RUN if start=1 (new operands latched as in REQ-014), otherwise IDLE.
REQ-019 Latency: when start is accepted on edge k, done SHALL be high in the cycle following edge k+WIDTH, and back-to-back operations SHALL achieve a throughput of one result per WIDTH+1 cycles.
REQ-020 busy SHALL equal (state == RUN); done SHALL equal (state == DONE); these two outputs are never high together.
REQ-021 start while in RUN SHALL be ignored, with no effect on the operation in progress or on the latched operands.
REQ-022 diff, bout and ovf SHALL change only on the completion edge of REQ-017 and SHALL hold their values in all other cycles, including through IDLE and a following RUN.
REQ-023 Changes on a, b or bin after the accepting edge SHALL have no effect on the result.
REQ-024 The bit counter SHALL be wide enough to count to WIDTH-1 and SHALL NOT wrap during RUN.

Reset
REQ-025 reset=1 SHALL immediately, with no clock required, force: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, and clear all internal registers.
REQ-026 A reset asserted during RUN or DONE SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-027 While reset=1, start SHALL be ignored.
REQ-028 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-029 a=0x05, b=0x03, bin=0, one start pulse -> done exactly 8 cycles after the accept edge; diff=0x02, bout=0, ovf=0; busy high for 8 cycles.
REQ-030 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0; a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-031 a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1, ovf=0; a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
REQ-032 Start held high continuously with a, b changing every cycle -> each result matches the operands present on its accept edge, and done pulses every 9 cycles.
REQ-033 Assert reset 4 cycles into RUN -> outputs go to 0 asynchronously and no done pulse follows; the next operation (a=0x10, b=0x01) gives diff=0x0F.
REQ-034 Randomized: 1000 operations compared against a reference model of a - b - bin, with bout and ovf checked, and diff held stable between done pulses.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// and publishes diff, borrow-out and signed overflow on completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // One full-subtractor slice acting on the current LSBs and running borrow.
    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & br) | (b_sh[0] & br);
        res_next = {d, res_sh[WIDTH-1:1]};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    // Overflow: borrow into the MSB differs from borrow out of it.
                    if (last_bit) begin
                        diff  <= res_next;
                        bout  <= br_next;
                        ovf   <= br ^ br_next;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=8): latency, results,
// back-to-back throughput, input isolation and asynchronous reset abort.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] last_diff;
    logic       last_bout;
    logic       last_ovf;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: {ovf, bout, diff} from plain unsigned and signed arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic mbin);
        logic [8:0] full;
        int         s;
        full = {1'b0, ma} - {1'b0, mb} - {8'd0, mbin};
        s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        return {(s > 127) || (s < -128), full[8], full[7:0]};
    endfunction

    // Issues one start, scrambles inputs and start while running, then checks
    // latency, busy length, held outputs and the final result at done.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_in, input logic tbin,
                                 input logic [7:0] e_diff, input logic e_bout, input logic e_ovf);
        int lat;
        int busy_cycles;
        bit seen;
        start = 1'b1;
        a     = ta;
        b     = tb_in;
        bin   = tbin;
        @(negedge clk);
        lat         = 0;
        busy_cycles = 0;
        seen        = 1'b0;
        while (lat < 20 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                checkOutput("hold_result", {diff, bout, ovf}, {last_diff, last_bout, last_ovf});
                start = 1'($urandom);
                a     = 8'($urandom);
                b     = 8'($urandom);
                bin   = 1'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(seen), 32'd1);
        checkOutput("latency", lat, 8);
        checkOutput("busy_cycles", busy_cycles, 8);
        checkOutput("busy_with_done", 32'(busy), 32'd0);
        checkOutput("diff", 32'(diff), 32'(e_diff));
        checkOutput("bout", 32'(bout), 32'(e_bout));
        checkOutput("ovf", 32'(ovf), 32'(e_ovf));
        last_diff = e_diff;
        last_bout = e_bout;
        last_ovf  = e_ovf;
    endtask

    logic [7:0] vec_a    [0:6] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h10};
    logic [7:0] vec_b    [0:6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    logic       vec_bin  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] vec_diff [0:6] = '{8'h02, 8'hFE, 8'h7F, 8'h00, 8'h80, 8'hFF, 8'h0F};
    logic       vec_bout [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       vec_ovf  [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic [7:0] qa   [0:35];
    logic [7:0] qb   [0:35];
    logic       qbin [0:35];

    initial begin
        logic [9:0] m;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        int         done_count;
        bit         exp_done;

        reset     = 1'b1;
        start     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        bin       = 1'b0;
        last_diff = 8'h00;
        last_bout = 1'b0;
        last_ovf  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_result", {diff, bout, ovf}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vec_a[i], vec_b[i], vec_bin[i], vec_diff[i], vec_bout[i], vec_ovf[i]);
            @(negedge clk);
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("idle_hold", {diff, bout, ovf}, {last_diff, last_bout, last_ovf});
        end

        // Start held high with fresh operands every cycle: results every 9 cycles.
        for (int j = 0; j <= 36; j++) begin
            if (j > 0) @(negedge clk);
            exp_done = (j > 0) && (j % 9 == 0);
            checkOutput("b2b_done", 32'(done), 32'(exp_done));
            checkOutput("b2b_exclusive", 32'(busy & done), 32'd0);
            if (exp_done) begin
                m = model(qa[j-9], qb[j-9], qbin[j-9]);
                checkOutput("b2b_result", {diff, bout, ovf}, {m[7:0], m[8], m[9]});
            end
            if (j < 36) begin
                qa[j]   = 8'($urandom);
                qb[j]   = 8'($urandom);
                qbin[j] = 1'($urandom);
                start   = 1'b1;
                a       = qa[j];
                b       = qb[j];
                bin     = qbin[j];
            end else begin
                start = 1'b0;
            end
        end
        m         = model(qa[27], qb[27], qbin[27]);
        last_diff = m[7:0];
        last_bout = m[8];
        last_ovf  = m[9];
        @(negedge clk);
        checkOutput("b2b_stop", 32'(done | busy), 32'd0);

        // Nonzero outputs first so the asynchronous clear is observable.
        applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h11;
        bin   = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_running", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_result", {diff, bout, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("reset_ignores_start", 32'(busy), 32'd0);
        start     = 1'b0;
        reset     = 1'b0;
        last_diff = 8'h00;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
        done_count = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_count++;
        end
        checkOutput("abort_no_done", done_count, 0);
        applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);

        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            m    = model(ra, rb, rbin);
            applyStimulus(ra, rb, rbin, m[7:0], m[8], m[9]);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                checkOutput("rand_idle_hold", {diff, bout, ovf}, {last_diff, last_bout, last_ovf});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
